// File: rtl/clock_monitor_pkg.sv
// Shared types and constants for the clock health monitor.
package clock_monitor_pkg;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned FAULT_W     = 8;

  typedef enum logic [2:0] {
    StWaitLock,
    StSettle,
    StMeasure,
    StCheck,
    StResetDcm
  } mon_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level. With EDGE_OUT set the output is the
// XOR of the synchronized level against a delayed copy (any-polarity transition strobe);
// otherwise the synchronized level itself is presented.
module sync_edge_detect
  import clock_monitor_pkg::*;
#(
  parameter bit EDGE_OUT = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_out
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Synchronizer chain plus edge reference register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= w_sync;
    end
  end

  assign o_out = EDGE_OUT ? (w_sync ^ r_prev) : w_sync;

endmodule

// File: rtl/clock_health_monitor.sv
// Measures monitored-clock activity (via a toggle flop) over fixed gate windows, flags
// out-of-range windows and requests a DCM reset after MAX_BAD consecutive bad windows.
module clock_health_monitor
  import clock_monitor_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 1000,
  parameter int unsigned EXPECT_MIN    = 180,
  parameter int unsigned EXPECT_MAX    = 220,
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter int unsigned RESET_PULSE   = 10,
  parameter int unsigned MAX_BAD       = 3,   // must fit in 8 bits
  parameter int unsigned CNT_W         = 16
) (
  input  logic               input_clk,
  input  logic               reset,
  input  logic               monitor_toggle,
  input  logic               dcm_locked,
  output logic               dcm_reset_req,
  output logic               clock_ok,
  output logic [CNT_W-1:0]   edge_count,
  output logic               count_valid,
  output logic [FAULT_W-1:0] fault_count,
  output logic               fault_sticky
);

  localparam logic [CNT_W-1:0]   WinLoad    = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SettleLoad = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   PulseLoad  = CNT_W'(RESET_PULSE - 1);
  localparam logic [CNT_W-1:0]   MinVal     = CNT_W'(EXPECT_MIN);
  localparam logic [CNT_W-1:0]   MaxVal     = CNT_W'(EXPECT_MAX);
  localparam logic [CNT_W-1:0]   CntOne     = CNT_W'(1);
  localparam logic [FAULT_W-1:0] FaultOne   = FAULT_W'(1);
  localparam logic [7:0]         BadLimit   = 8'(MAX_BAD);

  logic               w_edge;
  logic               w_lock;

  mon_state_t         r_state,  w_state_nxt;
  logic [CNT_W-1:0]   r_timer,  w_timer_nxt;
  logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
  logic [7:0]         r_bad,    w_bad_nxt;
  logic [7:0]         w_bad_inc;
  logic [CNT_W-1:0]   r_ecnt,   w_ecnt_nxt;
  logic               r_valid,  w_valid_nxt;
  logic               r_ok,     w_ok_nxt;
  logic               r_req,    w_req_nxt;
  logic [FAULT_W-1:0] r_fault,  w_fault_nxt;
  logic               r_sticky, w_sticky_nxt;
  logic               w_in_range;

  sync_edge_detect #(
    .EDGE_OUT (1'b1)
  ) u_toggle_sync (
    .i_clk   (input_clk),
    .i_rst   (reset),
    .i_async (monitor_toggle),
    .o_out   (w_edge)
  );

  sync_edge_detect #(
    .EDGE_OUT (1'b0)
  ) u_lock_sync (
    .i_clk   (input_clk),
    .i_rst   (reset),
    .i_async (dcm_locked),
    .o_out   (w_lock)
  );

  assign w_bad_inc  = r_bad + 8'd1;
  assign w_in_range = (r_cnt >= MinVal) && (r_cnt <= MaxVal);

  // Next-state and registered-output logic for the supervision FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_cnt_nxt    = r_cnt;
    w_bad_nxt    = r_bad;
    w_ecnt_nxt   = r_ecnt;
    w_valid_nxt  = 1'b0;
    w_ok_nxt     = r_ok;
    w_req_nxt    = r_req;
    w_fault_nxt  = r_fault;
    w_sticky_nxt = r_sticky;

    unique case (r_state)
      StWaitLock: begin
        w_ok_nxt = 1'b0;
        if (w_lock) begin
          w_timer_nxt = SettleLoad;
          w_state_nxt = StSettle;
        end
      end
      StSettle: begin
        if (!w_lock) begin
          w_ok_nxt    = 1'b0;
          w_state_nxt = StWaitLock;
        end else if (r_timer == '0) begin
          w_cnt_nxt   = '0;
          w_timer_nxt = WinLoad;
          w_state_nxt = StMeasure;
        end else begin
          w_timer_nxt = r_timer - CntOne;
        end
      end
      StMeasure: begin
        if (!w_lock) begin
          // Partial window is dropped; edge_count and bad counter keep their values.
          w_ok_nxt    = 1'b0;
          w_state_nxt = StWaitLock;
        end else begin
          if (w_edge && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + CntOne;
          end
          if (r_timer == '0) begin
            w_state_nxt = StCheck;
          end else begin
            w_timer_nxt = r_timer - CntOne;
          end
        end
      end
      StCheck: begin
        if (!w_lock) begin
          w_ok_nxt    = 1'b0;
          w_state_nxt = StWaitLock;
        end else begin
          w_ecnt_nxt  = r_cnt;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_timer_nxt = WinLoad;
          w_state_nxt = StMeasure;
          if (w_in_range) begin
            w_ok_nxt  = 1'b1;
            w_bad_nxt = '0;
          end else begin
            w_ok_nxt  = 1'b0;
            w_bad_nxt = w_bad_inc;
            if (w_bad_inc >= BadLimit) begin
              w_timer_nxt  = PulseLoad;
              w_req_nxt    = 1'b1;
              w_sticky_nxt = 1'b1;
              w_state_nxt  = StResetDcm;
              if (r_fault != '1) begin
                w_fault_nxt = r_fault + FaultOne;
              end
            end
          end
        end
      end
      StResetDcm: begin
        // Lock status is deliberately ignored until the pulse completes.
        if (r_timer == '0) begin
          w_req_nxt   = 1'b0;
          w_bad_nxt   = '0;
          w_state_nxt = StWaitLock;
        end else begin
          w_timer_nxt = r_timer - CntOne;
        end
      end
      default: begin
        w_state_nxt = StWaitLock;
      end
    endcase
  end

  // State and output registers; reset aborts any window or pulse immediately.
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      r_state  <= StWaitLock;
      r_timer  <= '0;
      r_cnt    <= '0;
      r_bad    <= '0;
      r_ecnt   <= '0;
      r_valid  <= 1'b0;
      r_ok     <= 1'b0;
      r_req    <= 1'b0;
      r_fault  <= '0;
      r_sticky <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bad    <= w_bad_nxt;
      r_ecnt   <= w_ecnt_nxt;
      r_valid  <= w_valid_nxt;
      r_ok     <= w_ok_nxt;
      r_req    <= w_req_nxt;
      r_fault  <= w_fault_nxt;
      r_sticky <= w_sticky_nxt;
    end
  end

  assign dcm_reset_req = r_req;
  assign clock_ok      = r_ok;
  assign edge_count    = r_ecnt;
  assign count_valid   = r_valid;
  assign fault_count   = r_fault;
  assign fault_sticky  = r_sticky;

endmodule

// File: tb/tb_clock_health_monitor.sv
// Self-checking bench for clock_health_monitor. Toggle stimulus is issued in lockstep with
// each window start so per-window transition counts are exact.
module tb_clock_health_monitor;

  logic        clk = 1'b0;
  logic        rst, tog, lock;
  logic        req, ok, valid, sticky;
  logic [15:0] ecnt;
  logic [7:0]  fcnt;

  logic        rst2, tog2, lock2;
  logic        req2, ok2, valid2, sticky2;
  logic [15:0] ecnt2;
  logic [7:0]  fcnt2;

  int n_tests = 0;
  int n_fail  = 0;
  bit req_seen;

  typedef struct {
    int period;
    int windows;
    int exp_count;
    bit exp_ok;
  } row_t;

  typedef struct {
    int count;
    bit ok;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  clock_health_monitor #(
    .WINDOW_CYCLES (100),
    .EXPECT_MIN    (18),
    .EXPECT_MAX    (22),
    .SETTLE_CYCLES (8),
    .RESET_PULSE   (10),
    .MAX_BAD       (3),
    .CNT_W         (16)
  ) dut (
    .input_clk      (clk),
    .reset          (rst),
    .monitor_toggle (tog),
    .dcm_locked     (lock),
    .dcm_reset_req  (req),
    .clock_ok       (ok),
    .edge_count     (ecnt),
    .count_valid    (valid),
    .fault_count    (fcnt),
    .fault_sticky   (sticky)
  );

  // Short windows so hundreds of DCM resets fit in a small cycle budget.
  clock_health_monitor #(
    .WINDOW_CYCLES (4),
    .EXPECT_MIN    (18),
    .EXPECT_MAX    (22),
    .SETTLE_CYCLES (1),
    .RESET_PULSE   (1),
    .MAX_BAD       (1),
    .CNT_W         (16)
  ) dut_sat (
    .input_clk      (clk),
    .reset          (rst2),
    .monitor_toggle (tog2),
    .dcm_locked     (lock2),
    .dcm_reset_req  (req2),
    .clock_ok       (ok2),
    .edge_count     (ecnt2),
    .count_valid    (valid2),
    .fault_count    (fcnt2),
    .fault_sticky   (sticky2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    tog  = 1'b0;
    lock = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait for count_valid at a falling edge, bounded.
  task automatic wait_valid(input int max, output int cycles, output bit got);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < max) begin
      @(negedge clk);
      cycles++;
      if (req) req_seen = 1'b1;
      got = valid;
    end
  endtask

  // Called at the window's first falling edge; toggles at offsets 0, p, 2p ... <= 97
  // all land inside this window. Returns at the next count_valid.
  task automatic drive_window(input int p, input int max, output int cycles, output bit got);
    int k;
    k   = 0;
    got = 1'b0;
    if (p > 0) tog = ~tog;
    while (!got && k < max) begin
      @(negedge clk);
      k++;
      if (req) req_seen = 1'b1;
      if (valid) got = 1'b1;
      else if (p > 0 && k < 98 && (k % p) == 0) tog = ~tog;
    end
    cycles = k;
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({name, "_count"}, int'(ecnt), e.count);
      check({name, "_ok"}, int'(ok), int'(e.ok));
    end
  endtask

  initial begin
    row_t rows[7];
    exp_t e;
    int   cyc;
    bit   got;
    int   hi;
    int   pulses;
    bit   prev;

    rows[0] = '{5, 2, 20, 1'b1};
    rows[1] = '{2, 2, 49, 1'b0};
    rows[2] = '{5, 1, 20, 1'b1};
    rows[3] = '{4, 2, 25, 1'b0};
    rows[4] = '{5, 1, 20, 1'b1};
    rows[5] = '{10, 2, 10, 1'b0};
    rows[6] = '{5, 1, 20, 1'b1};

    rst   = 1'b1;
    rst2  = 1'b1;
    tog   = 1'b0;
    tog2  = 1'b0;
    lock  = 1'b0;
    lock2 = 1'b1;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_req",    int'(req),    0);
    check("rst_ok",     int'(ok),     0);
    check("rst_ecnt",   int'(ecnt),   0);
    check("rst_valid",  int'(valid),  0);
    check("rst_fcnt",   int'(fcnt),   0);
    check("rst_sticky", int'(sticky), 0);

    // Table-driven windows: lock held, rate changes at window boundaries.
    do_reset();
    req_seen = 1'b0;
    lock = 1'b1;
    e = '{0, 1'b0};
    sb.push_back(e);
    wait_valid(200, cyc, got);
    check("first_valid_seen", int'(got), 1);
    check("first_valid_lat", cyc, 112);
    pop_check("win0");
    for (int r = 0; r < 7; r++) begin
      for (int w = 0; w < rows[r].windows; w++) begin
        e = '{rows[r].exp_count, rows[r].exp_ok};
        sb.push_back(e);
        drive_window(rows[r].period, 200, cyc, got);
        check($sformatf("row%0d_w%0d_seen", r, w), int'(got), 1);
        check($sformatf("row%0d_w%0d_period", r, w), cyc, 101);
        pop_check($sformatf("row%0d_w%0d", r, w));
      end
    end
    check("table_no_dcm_req", int'(req_seen), 0);
    check("table_fcnt", int'(fcnt), 0);

    // Stopped clock: three bad windows then a 10-cycle DCM reset request.
    do_reset();
    lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid(250, cyc, got);
      check($sformatf("stop_w%0d_seen", i), int'(got), 1);
      check($sformatf("stop_w%0d_count", i), int'(ecnt), 0);
      check($sformatf("stop_w%0d_ok", i), int'(ok), 0);
    end
    hi = 0;
    while (req && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    check("stop_req_len", hi, 10);
    check("stop_fcnt", int'(fcnt), 1);
    check("stop_sticky", int'(sticky), 1);
    check("stop_ok", int'(ok), 0);

    // Lock drop 40 cycles into a window following a good one.
    do_reset();
    lock = 1'b1;
    wait_valid(200, cyc, got);
    check("drop_w0_seen", int'(got), 1);
    drive_window(5, 200, cyc, got);
    check("drop_w1_seen", int'(got), 1);
    check("drop_w1_count", int'(ecnt), 20);
    check("drop_w1_ok", int'(ok), 1);
    tog = ~tog;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if ((k % 5) == 0) tog = ~tog;
    end
    lock = 1'b0;
    @(negedge clk);
    check("drop_ok_c1", int'(ok), 1);
    @(negedge clk);
    check("drop_ok_c2", int'(ok), 1);
    @(negedge clk);
    check("drop_ok_c3", int'(ok), 0);
    wait_valid(150, cyc, got);
    check("drop_no_valid", int'(got), 0);
    check("drop_ecnt_kept", int'(ecnt), 20);
    lock = 1'b1;
    wait_valid(200, cyc, got);
    check("relock_seen", int'(got), 1);
    check("relock_lat", cyc, 112);
    check("relock_count", int'(ecnt), 0);

    // Asynchronous reset during the fourth cycle of the DCM reset pulse.
    do_reset();
    lock = 1'b1;
    for (int i = 0; i < 3; i++) wait_valid(250, cyc, got);
    check("ar_req_before", int'(req), 1);
    check("ar_fcnt_before", int'(fcnt), 1);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("ar_req", int'(req), 0);
    check("ar_fcnt", int'(fcnt), 0);
    check("ar_sticky", int'(sticky), 0);
    check("ar_ok", int'(ok), 0);
    @(negedge clk);
    rst = 1'b0;

    // Fault counter saturation on the short-window instance.
    @(negedge clk);
    rst2   = 1'b0;
    pulses = 0;
    prev   = 1'b0;
    cyc    = 0;
    while (pulses < 256 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (req2 && !prev) begin
        pulses++;
        if (pulses == 1)   check("sat_fcnt_1", int'(fcnt2), 1);
        if (pulses == 255) check("sat_fcnt_255", int'(fcnt2), 255);
      end
      prev = req2;
    end
    check("sat_pulses", pulses, 256);
    check("sat_fcnt_hold", int'(fcnt2), 255);
    check("sat_sticky", int'(sticky2), 1);
    check("sat_ok", int'(ok2), 0);
    check("sat_ecnt", int'(ecnt2), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
